alarm_ring_ctrl: RTL and testbench

Alarm ring scheduler for the min:sec digital clock. It sits between the alarm-match logic and the buzzer melody generator. It turns a time-match event into a bounded ring session, with optional snooze cycles, a stop request and a lock-out. Its output gates the buzzer enable and drives a snooze blink for the display decimal point.

---
 rtl/alarm_ring_ctrl.sv | 148 ++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring scheduler: match event -> bounded ring session, snooze, stop, lock-out.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tick_1hz,
   input  logic       i_alarm_match,
   input  logic       i_alarm_en,
   input  logic       i_snooze,
   input  logic       i_stop,
   output logic       o_buzz_en,
   output logic       o_blink,
   output logic [1:0] o_state,
   output logic [2:0] o_snooze_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RING   = 2'b01,
      S_SNOOZE = 2'b10,
      S_LOCK   = 2'b11
   } state_t;

   localparam logic [8:0] RING_T   = 9'(RING_SEC);
   localparam logic [8:0] SNOOZE_T = 9'(SNOOZE_SEC);
   localparam logic [2:0] MAX_T    = 3'(MAX_SNOOZE);

   state_t     state_q;
   state_t     state_nx;
   logic [8:0] timer_q;
   logic [8:0] timer_nx;
   logic [2:0] cnt_q;
   logic [2:0] cnt_nx;
   logic       blink_q;
   logic       blink_nx;
   logic       buzz_q;
   logic       match_d;
   logic       trigger;

   // Rising edge of the match level only; LOCK covers the rest of the second.
   assign trigger = i_alarm_match & ~match_d & i_alarm_en;

   always_comb begin
      state_nx = state_q;
      timer_nx = timer_q;
      cnt_nx   = cnt_q;
      blink_nx = blink_q;
      if (!i_alarm_en) begin
         state_nx = S_IDLE;
         cnt_nx   = 3'd0;
         blink_nx = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  state_nx = S_RING;
                  timer_nx = RING_T;
                  cnt_nx   = 3'd0;
               end
            end
            S_RING: begin
               if (i_stop) begin
                  state_nx = S_LOCK;
`ifdef ALARM_SNOOZE_EN
               end else if (i_snooze && (cnt_q < MAX_T)) begin
                  state_nx = S_SNOOZE;
                  timer_nx = SNOOZE_T;
                  cnt_nx   = cnt_q + 3'd1;
                  blink_nx = 1'b0;
`endif
               end else if (i_tick_1hz) begin
                  if (timer_q == 9'd1) begin
                     state_nx = S_LOCK;
                  end else if (timer_q != 9'd0) begin
                     timer_nx = timer_q - 9'd1;
                  end
               end
            end
            S_SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
               if (i_stop) begin
                  state_nx = S_LOCK;
               end else if (i_tick_1hz) begin
                  if (timer_q == 9'd1) begin
                     state_nx = S_RING;
                     timer_nx = RING_T;
                     blink_nx = 1'b0;
                  end else if (timer_q != 9'd0) begin
                     timer_nx = timer_q - 9'd1;
                     blink_nx = ~blink_q;
                  end
               end
`else
               state_nx = S_IDLE;
`endif
            end
            S_LOCK: begin
               if (!i_alarm_match) begin
                  state_nx = S_IDLE;
               end
            end
            default: begin
               state_nx = S_IDLE;
            end
         endcase
      end
      // Blink is only meaningful while snoozing.
      if (state_nx != S_SNOOZE) begin
         blink_nx = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= 9'd0;
         cnt_q   <= 3'd0;
         blink_q <= 1'b0;
         buzz_q  <= 1'b0;
         match_d <= 1'b0;
      end else begin
         state_q <= state_nx;
         timer_q <= timer_nx;
         cnt_q   <= cnt_nx;
         blink_q <= blink_nx;
         buzz_q  <= (state_nx == S_RING);
         match_d <= i_alarm_match;
      end
   end

   assign o_buzz_en = buzz_q;
   assign o_state   = state_q;

`ifdef ALARM_SNOOZE_EN
   assign o_blink      = blink_q;
   assign o_snooze_cnt = cnt_q;
`else
   logic unused_snooze;
   assign unused_snooze = i_snooze;
   assign o_blink       = 1'b0;
   assign o_snooze_cnt  = 3'd0;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed scoreboard bench for alarm_ring_ctrl (RING=3, SNOOZE=2, MAX=1).
// Snooze scenarios run when ALARM_SNOOZE_EN is defined, macro-off checks otherwise.
module tb_alarm_ring_ctrl;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RING = 2'b01;
   localparam logic [1:0] SNZ  = 2'b10;
   localparam logic [1:0] LOCK = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       match;
   logic       en;
   logic       snooze;
   logic       stop;
   logic       buzz;
   logic       blink;
   logic [1:0] st;
   logic [2:0] cnt;

   int compared = 0;
   int mism     = 0;

   typedef struct {
      string      tag;
      logic [6:0] v;
   } exp_t;

   exp_t exp_q[$];

   alarm_ring_ctrl #(
      .RING_SEC  (3),
      .SNOOZE_SEC(2),
      .MAX_SNOOZE(1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_tick_1hz   (tick),
      .i_alarm_match(match),
      .i_alarm_en   (en),
      .i_snooze     (snooze),
      .i_stop       (stop),
      .o_buzz_en    (buzz),
      .o_blink      (blink),
      .o_state      (st),
      .o_snooze_cnt (cnt)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [1:0] s,
                       input logic b, input logic bl, input logic [2:0] c);
      exp_t e;
      e.tag = tag;
      e.v   = {s, b, bl, c};
      exp_q.push_back(e);
   endtask

   // One clock; results of the inputs just driven are compared here.
   task automatic cyc();
      exp_t       e;
      logic [6:0] obs;
      @(posedge clk);
      #1;
      obs = {st, buzz, blink, cnt};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         assert (obs === e.v) else begin
            mism++;
            $error("FAIL %s observed st/buzz/blink/cnt=%b expected=%b",
                   e.tag, obs, e.v);
         end
      end
   endtask

   // One second: nine quiet cycles then a tick cycle that is checked.
   task automatic sec(input string tag, input logic [1:0] s,
                      input logic b, input logic bl, input logic [2:0] c);
      repeat (9) cyc();
      tick = 1'b1;
      push(tag, s, b, bl, c);
      cyc();
      tick = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      tick   = 1'b0;
      match  = 1'b0;
      en     = 1'b1;
      snooze = 1'b0;
      stop   = 1'b0;
      push("reset", IDLE, 0, 0, 3'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      push("idle", IDLE, 0, 0, 3'd0);
      cyc();

      // basic ring, match held for 5 seconds
      match = 1'b1;
      push("trig", RING, 1, 0, 3'd0);
      cyc();
      sec("ring_t1", RING, 1, 0, 3'd0);
      sec("ring_t2", RING, 1, 0, 3'd0);
      sec("ring_t3", LOCK, 0, 0, 3'd0);
      sec("lock_t4", LOCK, 0, 0, 3'd0);
      sec("lock_t5", LOCK, 0, 0, 3'd0);
      match = 1'b0;
      push("lock_exit", IDLE, 0, 0, 3'd0);
      cyc();

      // stop + snooze + tick together
      match = 1'b1;
      push("trig2", RING, 1, 0, 3'd0);
      cyc();
      sec("ring2_t1", RING, 1, 0, 3'd0);
      repeat (9) cyc();
      stop   = 1'b1;
      snooze = 1'b1;
      tick   = 1'b1;
      push("stop_prio", LOCK, 0, 0, 3'd0);
      cyc();
      stop   = 1'b0;
      snooze = 1'b0;
      tick   = 1'b0;
      sec("lock_hold", LOCK, 0, 0, 3'd0);
      match = 1'b0;
      push("lock_exit2", IDLE, 0, 0, 3'd0);
      cyc();

      // disabled alarm never triggers, re-enable mid-match neither
      en    = 1'b0;
      match = 1'b1;
      push("dis_match", IDLE, 0, 0, 3'd0);
      cyc();
      en = 1'b1;
      push("reen_nomatch", IDLE, 0, 0, 3'd0);
      cyc();
      match = 1'b0;
      cyc();

`ifdef ALARM_SNOOZE_EN
      // snooze limit
      match = 1'b1;
      push("s_trig", RING, 1, 0, 3'd0);
      cyc();
      sec("s_ring_t1", RING, 1, 0, 3'd0);
      snooze = 1'b1;
      push("s_snooze", SNZ, 0, 0, 3'd1);
      cyc();
      snooze = 1'b0;
      sec("s_blink", SNZ, 0, 1, 3'd1);
      sec("s_resume", RING, 1, 0, 3'd1);
      snooze = 1'b1;
      push("s_limit", RING, 1, 0, 3'd1);
      cyc();
      snooze = 1'b0;
      sec("s_ring_a", RING, 1, 0, 3'd1);
      sec("s_ring_b", RING, 1, 0, 3'd1);
      sec("s_expire", LOCK, 0, 0, 3'd1);
      match = 1'b0;
      push("s_idle", IDLE, 0, 0, 3'd1);
      cyc();

      // disable mid-snooze
      match = 1'b1;
      push("d_trig", RING, 1, 0, 3'd0);
      cyc();
      snooze = 1'b1;
      push("d_snooze", SNZ, 0, 0, 3'd1);
      cyc();
      snooze = 1'b0;
      sec("d_blink", SNZ, 0, 1, 3'd1);
      en = 1'b0;
      push("d_disable", IDLE, 0, 0, 3'd0);
      cyc();
      en = 1'b1;
      push("d_reen", IDLE, 0, 0, 3'd0);
      cyc();
      sec("d_noretrig", IDLE, 0, 0, 3'd0);
      match = 1'b0;
      cyc();
`else
      // snooze has no effect without the feature
      match = 1'b1;
      push("n_trig", RING, 1, 0, 3'd0);
      cyc();
      snooze = 1'b1;
      push("n_snooze", RING, 1, 0, 3'd0);
      cyc();
      snooze = 1'b0;
      sec("n_t1", RING, 1, 0, 3'd0);
      sec("n_t2", RING, 1, 0, 3'd0);
      sec("n_t3", LOCK, 0, 0, 3'd0);
      match = 1'b0;
      push("n_idle", IDLE, 0, 0, 3'd0);
      cyc();
`endif

      // disable while ringing
      match = 1'b1;
      push("r_trig", RING, 1, 0, 3'd0);
      cyc();
      en = 1'b0;
      push("r_disable", IDLE, 0, 0, 3'd0);
      cyc();
      en    = 1'b1;
      match = 1'b0;
      cyc();

      // reset mid-ring with match still high
      match = 1'b1;
      push("x_trig", RING, 1, 0, 3'd0);
      cyc();
      sec("x_t1", RING, 1, 0, 3'd0);
      rst_n = 1'b0;
      push("x_reset", IDLE, 0, 0, 3'd0);
      cyc();
      rst_n = 1'b1;
      push("x_retrig", RING, 1, 0, 3'd0);
      cyc();
      sec("x_t1b", RING, 1, 0, 3'd0);
      sec("x_t2b", RING, 1, 0, 3'd0);
      sec("x_t3b", LOCK, 0, 0, 3'd0);
      match = 1'b0;
      push("x_idle", IDLE, 0, 0, 3'd0);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
